// File: rtl/calc_pkg.sv
// Shared constants and helpers for the two-operand calculator.
// Holds the state codes driven on Estado and the operand ceiling, so the
// controller and the display selector decode the same values.
package calc_pkg;

    // State codes; 5..7 are illegal and force a return to OFF.
    localparam logic [2:0] OFF  = 3'd0;
    localparam logic [2:0] SOMA = 3'd1;
    localparam logic [2:0] SUB  = 3'd2;
    localparam logic [2:0] MULT = 3'd3;
    localparam logic [2:0] ON   = 3'd4;

    localparam logic [6:0] MAX_OPERANDO = 7'd99;

    // Operands saturate at 99 so they always fit two decimal digits.
    function automatic logic [6:0] limita_operando(input logic [6:0] valor);
        return (valor > MAX_OPERANDO) ? MAX_OPERANDO : valor;
    endfunction

    // Operation advance: On enters Soma, and Mult wraps back to Soma.
    function automatic logic [2:0] proxima_operacao(input logic [2:0] estado);
        logic [2:0] proximo;
        case (estado)
            ON:      proximo = SOMA;
            SOMA:    proximo = SUB;
            SUB:     proximo = MULT;
            default: proximo = SOMA;
        endcase
        return proximo;
    endfunction

endpackage

// File: rtl/detector_botao.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and
// one-cycle press pulse on each accepted rising level.
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high
//   btn_raw  - raw asynchronous button level
//   pressao  - one-cycle pulse per accepted press (never on release)
module detector_botao #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pressao
);

    // The counter reaches LIMITE on the DEBOUNCE_CYCLES-th consecutive
    // differing cycle, which is the cycle the new level is accepted.
    localparam logic [15:0] LIMITE = 16'(DEBOUNCE_CYCLES - 1);

    logic        sinc1;
    logic        sinc2;
    logic        nivel;
    logic [15:0] contador;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, making the synchronizer
    // chain shift by exactly one stage per clock.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it is just the highest-priority branch
        // of the clocked logic and needs no entry in the sensitivity list.
        if (reset) begin
            sinc1    <= 1'b0;
            sinc2    <= 1'b0;
            nivel    <= 1'b0;
            contador <= '0;
            pressao  <= 1'b0;
        end else begin
            sinc1   <= btn_raw;
            sinc2   <= sinc1;
            pressao <= 1'b0;
            if (sinc2 == nivel) begin
                // Any agreement breaks the run of differing samples.
                contador <= '0;
            end else if (contador == LIMITE) begin
                nivel    <= sinc2;
                contador <= '0;
                pressao  <= sinc2;
            end else begin
                contador <= contador + 16'd1;
            end
        end
    end

endmodule

// File: rtl/controle_calculadora.sv
// Front-end controller of the two-operand calculator.
// Conditions the four buttons, synchronizes the switch bank, runs the
// power/operation state machine and holds the two clamped operands.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   Chaves[6:0]         - operand switches (asynchronous)
//   BtnLiga, BtnOper    - power toggle, operation advance (raw)
//   BtnN1, BtnN2        - load switches into operand 1 / 2 (raw)
//   Estado[2:0]         - state code (Off=0 Soma=1 Sub=2 Mult=3 On=4)
//   N1[6:0], N2[6:0]    - registered operands, 0..99
module controle_calculadora
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Chaves,
    input  logic       BtnLiga,
    input  logic       BtnOper,
    input  logic       BtnN1,
    input  logic       BtnN2,
    output logic [2:0] Estado,
    output logic [6:0] N1,
    output logic [6:0] N2
);

    logic       p_liga;
    logic       p_oper;
    logic       p_n1;
    logic       p_n2;

    logic [6:0] chaves_s1;
    logic [6:0] chaves_s2;

    logic [2:0] estado_q;
    logic [2:0] estado_nxt;
    logic [6:0] n1_q;
    logic [6:0] n1_nxt;
    logic [6:0] n2_q;
    logic [6:0] n2_nxt;
    logic [6:0] valor;

    detector_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_liga (
        .clk(clk), .reset(reset), .btn_raw(BtnLiga), .pressao(p_liga)
    );
    detector_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_oper (
        .clk(clk), .reset(reset), .btn_raw(BtnOper), .pressao(p_oper)
    );
    detector_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_n1 (
        .clk(clk), .reset(reset), .btn_raw(BtnN1), .pressao(p_n1)
    );
    detector_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_n2 (
        .clk(clk), .reset(reset), .btn_raw(BtnN2), .pressao(p_n2)
    );

    // Switches are sampled bit-wise through two flops. A bit caught mid-change
    // can only matter if the user moves switches during a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            chaves_s1 <= '0;
            chaves_s2 <= '0;
        end else begin
            chaves_s1 <= Chaves;
            chaves_s2 <= chaves_s1;
        end
    end

    assign valor = limita_operando(chaves_s2);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        estado_nxt = estado_q;
        n1_nxt     = n1_q;
        n2_nxt     = n2_q;
        case (estado_q)
            OFF: begin
                // Power-on leaves the (already zero) operands alone; any
                // other press in Off is discarded.
                if (p_liga) estado_nxt = ON;
            end
            ON, SOMA, SUB, MULT: begin
                if (p_liga) begin
                    // Power press wins over every concurrent press.
                    estado_nxt = OFF;
                    n1_nxt     = '0;
                    n2_nxt     = '0;
                end else begin
                    if (p_oper) estado_nxt = proxima_operacao(estado_q);
                    if (p_n1)   n1_nxt     = valor;
                    if (p_n2)   n2_nxt     = valor;
                end
            end
            default: begin
                // Illegal code: recover to Off with cleared operands.
                estado_nxt = OFF;
                n1_nxt     = '0;
                n2_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= OFF;
            n1_q     <= '0;
            n2_q     <= '0;
        end else begin
            estado_q <= estado_nxt;
            n1_q     <= n1_nxt;
            n2_q     <= n2_nxt;
        end
    end

    assign Estado = estado_q;
    assign N1     = n1_q;
    assign N2     = n2_q;

endmodule
